// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the default multiply latency.
package md_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_NOP6  = 3'd6,
      OP_NOP7  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } md_state_e;

   localparam int DEFAULT_MULT_CYCLES = 5;

endpackage

// File: rtl/md_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and md_unit.
interface md_if #(parameter int WIDTH = 32);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, flush, input busy, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, hi, lo);

endinterface

// File: rtl/md_divider.sv
// Iterative radix-2 restoring divider on unsigned operands, one quotient bit
// per cycle; o_done pulses for one cycle after the last step.
module md_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_run;
   logic             r_done;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_sub;
   logic             w_ge;

   // Partial remainder needs one extra bit after the shift before the compare.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_sub   = w_shift - {1'b0, r_div};
   assign w_ge    = (w_shift >= {1'b0, r_div});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_abort) begin
            r_run <= 1'b0;
            r_cnt <= '0;
         end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_cnt <= CNT_W'(WIDTH);
            r_run <= 1'b1;
         end else if (r_run) begin
            r_rem <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_done      = r_done;
   assign o_quotient  = r_quo;
   assign o_remainder = r_rem;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy is registered and HI/LO
// only change on an MTHI/MTLO or on the final edge of a completed operation.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   md_if.slave  bus
);

   localparam int CNT_MAX = (MULT_CYCLES > WIDTH) ? MULT_CYCLES : WIDTH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   md_state_e          r_state;
   logic               r_busy;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_mulA;
   logic [2*WIDTH-1:0] r_mulB;
   logic [2*WIDTH-1:0] r_prod;
   logic               r_qNeg;
   logic               r_rNeg;
   logic               r_divZero;

   md_op_e             w_op;
   logic               w_signed;
   logic [2*WIDTH-1:0] w_extA;
   logic [2*WIDTH-1:0] w_extB;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_mulResult;
   logic [WIDTH-1:0]   w_absA;
   logic [WIDTH-1:0]   w_absB;
   logic               w_divStart;
   logic               w_divDone;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_op     = md_op_e'(bus.op);
   assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);

   // Sign-extending to 2W lets one unsigned multiplier serve MULT and MULTU.
   assign w_extA = w_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
   assign w_extB = w_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
   assign w_prod = r_mulA * r_mulB;
   assign w_mulResult = (MULT_CYCLES == 1) ? w_prod : r_prod;

   assign w_absA = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign w_absB = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   assign w_divStart = (r_state == IDLE) && bus.start && !bus.flush &&
                       ((w_op == OP_DIV) || (w_op == OP_DIVU));

   md_divider #(.WIDTH(WIDTH)) u_divider (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_start     (w_divStart),
      .i_abort     (bus.flush),
      .i_dividend  (w_absA),
      .i_divisor   (w_absB),
      .o_done      (w_divDone),
      .o_quotient  (w_quo),
      .o_remainder (w_rem)
   );

   // Flush overrides everything, including a start sampled in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_mulA    <= '0;
         r_mulB    <= '0;
         r_prod    <= '0;
         r_qNeg    <= 1'b0;
         r_rNeg    <= 1'b0;
         r_divZero <= 1'b0;
      end else if (bus.flush) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  case (w_op)
                     OP_MULT, OP_MULTU: begin
                        r_mulA  <= w_extA;
                        r_mulB  <= w_extB;
                        r_cnt   <= CNT_W'(MULT_CYCLES);
                        r_state <= MUL;
                        r_busy  <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        r_qNeg    <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_rNeg    <= w_signed && bus.a[WIDTH-1];
                        r_divZero <= (bus.b == '0);
                        r_cnt     <= CNT_W'(WIDTH);
                        r_state   <= DIV;
                        r_busy    <= 1'b1;
                     end
                     OP_MTHI: r_hi <= bus.a;
                     OP_MTLO: r_lo <= bus.a;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               r_prod <= w_prod;
               if (r_cnt == CNT_W'(1)) begin
                  r_hi    <= w_mulResult[2*WIDTH-1:WIDTH];
                  r_lo    <= w_mulResult[WIDTH-1:0];
                  r_cnt   <= '0;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DIV: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_cnt   <= '0;
                  r_state <= FIX;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            FIX: begin
               if (w_divDone && !r_divZero) begin
                  r_lo <= r_qNeg ? -w_quo : w_quo;
                  r_hi <= r_rNeg ? -w_rem : w_rem;
               end
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: multiply/divide results, busy durations,
// MTHI/MTLO, flush handling and asynchronous reset.
module tb_md_unit;
   import md_pkg::*;

   logic clk;
   logic reset_n;
   int   checkCount;
   int   errorCount;
   int   cycles;

   md_if #(.WIDTH(32)) bus ();

   md_unit #(.WIDTH(32), .MULT_CYCLES(5)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Issues one op for a single cycle, then counts edges until busy drops.
   task automatic applyStimulus(input logic [2:0] opc, input logic [31:0] av,
                                input logic [31:0] bv, output int busyCycles);
      bus.start = 1'b1;
      bus.op    = opc;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      busyCycles = 0;
      while (bus.busy && busyCycles < 100) begin
         @(posedge clk);
         #1;
         busyCycles++;
      end
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      reset_n    = 1'b0;
      bus.start  = 1'b0;
      bus.op     = OP_NOP6;
      bus.a      = '0;
      bus.b      = '0;
      bus.flush  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset hi", bus.hi, 32'h0);
      checkOutput("reset lo", bus.lo, 32'h0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, cycles);
      checkOutput("mult busy", 32'(cycles), 32'd5);
      checkOutput("mult hi", bus.hi, 32'hFFFFFFFF);
      checkOutput("mult lo", bus.lo, 32'hFFFFFFFA);

      applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cycles);
      checkOutput("multu busy", 32'(cycles), 32'd5);
      checkOutput("multu hi", bus.hi, 32'hFFFFFFFE);
      checkOutput("multu lo", bus.lo, 32'h00000001);

      applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, cycles);
      checkOutput("mult neg hi", bus.hi, 32'h0);
      checkOutput("mult neg lo", bus.lo, 32'd15);

      applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, cycles);
      checkOutput("div busy", 32'(cycles), 32'd33);
      checkOutput("div lo", bus.lo, 32'hFFFFFFFD);
      checkOutput("div hi", bus.hi, 32'hFFFFFFFF);

      applyStimulus(OP_DIVU, 32'd100, 32'd7, cycles);
      checkOutput("divu busy", 32'(cycles), 32'd33);
      checkOutput("divu lo", bus.lo, 32'd14);
      checkOutput("divu hi", bus.hi, 32'd2);

      applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cycles);
      checkOutput("div ovf lo", bus.lo, 32'h80000000);
      checkOutput("div ovf hi", bus.hi, 32'h0);

      applyStimulus(OP_DIV, 32'd7, 32'hFFFFFFFE, cycles);
      checkOutput("div negb lo", bus.lo, 32'hFFFFFFFD);
      checkOutput("div negb hi", bus.hi, 32'd1);

      applyStimulus(OP_MTHI, 32'h11, 32'h0, cycles);
      checkOutput("mthi busy", 32'(cycles), 32'd0);
      checkOutput("mthi hi", bus.hi, 32'h11);
      applyStimulus(OP_MTLO, 32'h22, 32'h0, cycles);
      checkOutput("mtlo lo", bus.lo, 32'h22);
      checkOutput("mtlo hi kept", bus.hi, 32'h11);

      applyStimulus(OP_DIVU, 32'd5, 32'd0, cycles);
      checkOutput("div0 busy", 32'(cycles), 32'd33);
      checkOutput("div0 hi", bus.hi, 32'h11);
      checkOutput("div0 lo", bus.lo, 32'h22);

      // MTHI in cycle 0, MULT in cycle 3, flush in cycle 6.
      applyStimulus(OP_MTHI, 32'hABCD, 32'h0, cycles);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checkOutput("flush pre busy", 32'(bus.busy), 32'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      checkOutput("flush busy", 32'(bus.busy), 32'd0);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      checkOutput("flush hi", bus.hi, 32'hABCD);
      checkOutput("flush lo", bus.lo, 32'h22);

      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.op    = OP_MTLO;
      bus.a     = 32'h999;
      @(posedge clk);
      #1;
      checkOutput("sflush mtlo", bus.lo, 32'h22);
      bus.op = OP_DIV;
      bus.a  = 32'd10;
      bus.b  = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      checkOutput("sflush busy", 32'(bus.busy), 32'd0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("sflush idle", 32'(bus.busy), 32'd0);

      // Reset asserted in cycle 10 of a divide.
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      checkOutput("rst mid busy pre", 32'(bus.busy), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("rst mid busy", 32'(bus.busy), 32'd0);
      checkOutput("rst mid hi", bus.hi, 32'h0);
      checkOutput("rst mid lo", bus.lo, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(OP_MULTU, 32'd6, 32'd7, cycles);
      checkOutput("post rst busy", 32'(cycles), 32'd5);
      checkOutput("post rst lo", bus.lo, 32'd42);
      checkOutput("post rst hi", bus.hi, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the EX stage, owning the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and reports `busy` to the hazard unit. The hazard unit turns `busy` into the `stall`/`clr` controls of the ID/EX and EX/MEM pipeline registers. HI/LO feed the EX result mux for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy duration of a multiply (≥1).
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  valid operation in EX this cycle.
- `op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 no-op.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `flush`  in  1  abort in-flight operation (exception / pipeline clear).
- `busy`  out  1  operation in progress; HI/LO not yet valid.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: `busy`=0.
  - MUL: counter counts down from MULT_CYCLES.
  - DIV: iteration counter runs WIDTH steps.
  - FIX: one sign-correction cycle.
- In IDLE, `start`=1 with MULT/MULTU:
  - Register the full 2·WIDTH product, signed or unsigned by op.
  - Enter MUL.
- In IDLE, `start`=1 with DIV/DIVU:
  - Latch |a| and |b| (raw values for DIVU) and the result signs.
  - Enter DIV.
  - Run a radix-2 restoring divide, one quotient bit per cycle, then FIX.
- Multiply result: HI = product[2W-1:W], LO = product[W-1:0].
- Divide result: LO = quotient, truncated toward zero; HI = remainder, sign follows dividend.
- Signed overflow: −2^(W−1) / −1 → LO=0x80000000, HI=0.
- Divide by zero: runs full duration; HI/LO unchanged.
- MTHI/MTLO: write `a` into HI/LO at the sampling edge; never asserts `busy`; stays in IDLE.
- `start` while `busy`=1 is ignored. The hazard unit guarantees this does not occur; the ignore behaviour is still required.
- `flush`=1: return to IDLE at the next edge; HI/LO unchanged; in-flight result discarded.
- `flush` and `start` in the same cycle: flush wins, operation not started, MTHI/MTLO not written.
- Reset: HI=0, LO=0, `busy`=0, state IDLE, counters 0. Reset mid-operation discards the operation.

## Timing
- Edge E0 is the edge sampling `start`=1.
- Multiply:
  - `busy`=1 after E0 through E(MULT_CYCLES).
  - HI/LO written at E(MULT_CYCLES); `busy`=0 after that edge.
  - Default: busy 5 cycles.
- Divide:
  - `busy`=1 for WIDTH+1 cycles (33 by default).
  - HI/LO written at E(WIDTH+1); `busy` falls at the same edge.
- `busy` is registered, with no combinational path from `start`. The hazard unit must combine `start` with the `busy` registered output to stall the ID stage in cycle 0.
- HI/LO outputs are registered and stable while `busy`=1; they hold previous values until the write edge.
- A new `start` is accepted in the first cycle `busy`=0, giving back-to-back operations with no bubble.

## Structure
- Package `md_pkg`:
  - `op` encodings: OP_MULT … OP_MTLO.
  - State encoding: IDLE/MUL/DIV/FIX.
  - Default MULT_CYCLES.
- Sub-module `md_divider`:
  - Iterative restoring core: start, unsigned dividend/divisor, done, quotient, remainder.
  - Sign handling and divide-by-zero detection stay in `md_unit`.
- Multiply uses the synthesizer's `*` on registered operands, padded with pipeline registers to MULT_CYCLES.

## Test plan
- Reset low mid-divide (cycle 10) → HI=LO=0, `busy`=0 immediately; a new MULTU after release completes normally.
- MULT a=0xFFFFFFFE (−2), b=3 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=−7, b=2 → `busy` 33 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 100/7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU by 0 with prior HI=0x11, LO=0x22 → unchanged after 33 cycles.
- MTHI 0xABCD in cycle 0, then MULT at cycle 3 with `flush` in cycle 6 → HI=0xABCD retained, `busy`=0 at cycle 7. `start`+`flush` same cycle → no busy, no write.
